// File: rtl/svn_seg_pkg.sv
// Shared types and constants for the multi-digit 7-segment counter.
package svn_seg_pkg;

  typedef logic [3:0] nibble_t;

  // Segment patterns, bits 6..0 = g..a, active-high, decimal point clear.
  localparam logic [6:0] SEG7DISP [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // All segments and the decimal point dark, before polarity is applied.
  localparam logic [7:0] SEG_OFF = 8'h00;

endpackage

// File: rtl/svn_seg_digit_cntr.sv
// One hex/BCD digit of the display counter: load, increment on carry, at-max flag.
module svn_seg_digit_cntr
  import svn_seg_pkg::*;
#(
  parameter bit DECIMAL = 1'b0
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       inc_i,
  input  logic       carry_i,
  output logic [3:0] digit_o,
  output logic       at_max_o
);

  localparam nibble_t DIGIT_MAX = DECIMAL ? 4'd9 : 4'd15;

  nibble_t digit_q, digit_d;
  logic    at_max;

  // Next digit value; a BCD nibble loaded above 9 counts as max and wraps with carry.
  always_comb begin
    at_max  = (digit_q >= DIGIT_MAX);
    digit_d = digit_q;
    if (load_i) begin
      digit_d = load_val_i;
    end else if (inc_i && carry_i) begin
      digit_d = at_max ? '0 : digit_q + 4'd1;
    end
  end

  // Digit register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit_o  = digit_q;
  assign at_max_o = at_max;

endmodule

// File: rtl/svn_seg_mux_cntr.sv
// NUM_DIGITS-digit hex/BCD counter with a time-multiplexed 7-segment output.
// Optional macro SVN_SEG_LEAD_ZERO_BLANK_EN blanks leading-zero digits above digit 0.
module svn_seg_mux_cntr
  import svn_seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 3,
  parameter int unsigned COUNT_DIV    = 125_000_000,
  parameter int unsigned SCAN_DIV     = 125_000,
  parameter bit          DECIMAL      = 1'b0,
  parameter bit          SEG_POLARITY = 1'b0,
  parameter bit          SEL_POLARITY = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    en_i,
  input  logic                    load_i,
  input  logic [4*NUM_DIGITS-1:0] load_val_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  output logic [4*NUM_DIGITS-1:0] count_o,
  output logic                    wrap_o,
  output logic [7:0]              seg_display_o,
  output logic [NUM_DIGITS-1:0]   seg_sel_o
);

  localparam int unsigned CW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0]         CNT_LAST  = CW'(COUNT_DIV - 1);
  localparam logic [SW-1:0]         SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]         IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] SEL_IDLE  = SEL_POLARITY ? '0 : '1;
  localparam logic [7:0]            SEG_IDLE  = SEG_POLARITY ? SEG_OFF : ~SEG_OFF;

  logic [CW-1:0]         cdiv_q, cdiv_d;
  logic [SW-1:0]         sdiv_q, sdiv_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  wrap_q, wrap_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  logic [7:0]            seg_q, seg_d;

  logic                  count_tick, scan_tick, inc;
  logic [NUM_DIGITS-1:0] at_max, carry;
  nibble_t               digit [NUM_DIGITS];

  // Free-running prescalers and scan index advance.
  always_comb begin
    count_tick = (cdiv_q == CNT_LAST);
    scan_tick  = (sdiv_q == SCAN_LAST);
    cdiv_d     = count_tick ? '0 : cdiv_q + 1'b1;
    sdiv_d     = scan_tick ? '0 : sdiv_q + 1'b1;
    idx_d      = idx_q;
    if (scan_tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // Increment qualification (load wins) and ripple carry: digit k steps when all lower digits are at max.
  always_comb begin
    logic acc;
    inc    = en_i && count_tick && !load_i;
    wrap_d = inc && (&at_max);
    acc    = 1'b1;
    carry  = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      carry[k] = acc;
      acc      = acc & at_max[k];
    end
  end

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    svn_seg_digit_cntr #(
      .DECIMAL (DECIMAL)
    ) u_digit (
      .clk_i      (clk_i),
      .rstn_i     (rstn_i),
      .load_i     (load_i),
      .load_val_i (load_val_i[4*k +: 4]),
      .inc_i      (inc),
      .carry_i    (carry[k]),
      .digit_o    (digit[k]),
      .at_max_o   (at_max[k])
    );
    assign count_o[4*k +: 4] = digit[k];
  end

  // Select and segment pattern for the current scan index, computed together so both register on the same edge.
  always_comb begin
    nibble_t               cur;
    logic                  dp;
    logic                  blank;
    logic [NUM_DIGITS-1:0] onehot;
    logic [6:0]            pat;
    cur    = '0;
    dp     = 1'b0;
    blank  = 1'b0;
    onehot = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (IW'(k) == idx_q) begin
        cur       = digit[k];
        dp        = dp_i[k];
        onehot[k] = 1'b1;
      end
    end
`ifdef SVN_SEG_LEAD_ZERO_BLANK_EN
    // Blank when this digit and every higher digit are zero; digit 0 always shows.
    blank = (idx_q != '0);
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if ((IW'(k) >= idx_q) && (digit[k] != '0)) begin
        blank = 1'b0;
      end
    end
`endif
    pat   = blank ? SEG_OFF[6:0] : SEG7DISP[cur];
    seg_d = SEG_POLARITY ? {dp, pat} : ~{dp, pat};
    sel_d = SEL_POLARITY ? onehot : ~onehot;
  end

  // State and registered outputs.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cdiv_q <= '0;
      sdiv_q <= '0;
      idx_q  <= '0;
      wrap_q <= 1'b0;
      sel_q  <= SEL_IDLE;
      seg_q  <= SEG_IDLE;
    end else begin
      cdiv_q <= cdiv_d;
      sdiv_q <= sdiv_d;
      idx_q  <= idx_d;
      wrap_q <= wrap_d;
      sel_q  <= sel_d;
      seg_q  <= seg_d;
    end
  end

  assign wrap_o        = wrap_q;
  assign seg_sel_o     = sel_q;
  assign seg_display_o = seg_q;

endmodule

// File: tb/tb_svn_seg_mux_cntr.sv
// Randomised self-checking bench: a hex instance (active-high outputs) and a BCD
// instance (active-low outputs) share stimulus and are compared to a digit-rule model.
module tb_svn_seg_mux_cntr;

  localparam int COUNT_DIV = 4;
  localparam int SCAN_DIV  = 2;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic        clk = 1'b0;
  logic        rstn, en, load;
  logic [11:0] load_val;
  logic [2:0]  dp;

  logic [11:0] h_count, d_count;
  logic        h_wrap, d_wrap;
  logic [7:0]  h_seg, d_seg;
  logic [2:0]  h_sel, d_sel;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  svn_seg_mux_cntr #(
    .NUM_DIGITS(3), .COUNT_DIV(COUNT_DIV), .SCAN_DIV(SCAN_DIV),
    .DECIMAL(1'b0), .SEG_POLARITY(1'b1), .SEL_POLARITY(1'b1)
  ) dut_hex (
    .clk_i(clk), .rstn_i(rstn), .en_i(en), .load_i(load), .load_val_i(load_val),
    .dp_i(dp), .count_o(h_count), .wrap_o(h_wrap), .seg_display_o(h_seg), .seg_sel_o(h_sel)
  );

  svn_seg_mux_cntr #(
    .NUM_DIGITS(3), .COUNT_DIV(COUNT_DIV), .SCAN_DIV(SCAN_DIV),
    .DECIMAL(1'b1), .SEG_POLARITY(1'b0), .SEL_POLARITY(1'b0)
  ) dut_dec (
    .clk_i(clk), .rstn_i(rstn), .en_i(en), .load_i(load), .load_val_i(load_val),
    .dp_i(dp), .count_o(d_count), .wrap_o(d_wrap), .seg_display_o(d_seg), .seg_sel_o(d_sel)
  );

  // ---------------- reference model ----------------
  function automatic logic [11:0] next_cnt(input logic [11:0] c, input bit dec);
    logic [11:0] r;
    int          mx;
    bit          cy;
    r  = c;
    mx = dec ? 9 : 15;
    cy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (cy) begin
        if (int'(c[4*k +: 4]) >= mx) r[4*k +: 4] = 4'h0;
        else begin
          r[4*k +: 4] = c[4*k +: 4] + 4'h1;
          cy = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic bit all_max(input logic [11:0] c, input bit dec);
    int mx;
    mx = dec ? 9 : 15;
    for (int k = 0; k < 3; k++)
      if (int'(c[4*k +: 4]) < mx) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [7:0] disp(input logic [11:0] c, input int idx,
                                      input logic [2:0] dpv, input bit act_hi);
    logic [3:0] d;
    logic [7:0] s;
    d = c[4*idx +: 4];
    s = {dpv[idx], SEG_TAB[d]};
`ifdef SVN_SEG_LEAD_ZERO_BLANK_EN
    if (idx > 0 && (c >> (4*idx)) == 12'h000) s = {dpv[idx], 7'h00};
`endif
    return act_hi ? s : ~s;
  endfunction

  function automatic logic [2:0] selv(input int idx, input bit act_hi);
    logic [2:0] s;
    s = 3'b001 << idx;
    return act_hi ? s : ~s;
  endfunction

  int          m_cdiv, m_sdiv, m_idx;
  logic [11:0] m_cnt  [2];
  logic        m_wrap [2];
  logic [7:0]  m_seg  [2];
  logic [2:0]  m_sel  [2];

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_cdiv <= 0;
      m_sdiv <= 0;
      m_idx  <= 0;
      for (int m = 0; m < 2; m++) begin
        m_cnt[m]  <= 12'h000;
        m_wrap[m] <= 1'b0;
        m_seg[m]  <= (m == 0) ? 8'h00 : 8'hFF;
        m_sel[m]  <= (m == 0) ? 3'b000 : 3'b111;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        m_sel[m] <= selv(m_idx, m == 0);
        m_seg[m] <= disp(m_cnt[m], m_idx, dp, m == 0);
        if (load) begin
          m_cnt[m]  <= load_val;
          m_wrap[m] <= 1'b0;
        end else if (en && m_cdiv == COUNT_DIV - 1) begin
          m_cnt[m]  <= next_cnt(m_cnt[m], m == 1);
          m_wrap[m] <= all_max(m_cnt[m], m == 1);
        end else begin
          m_wrap[m] <= 1'b0;
        end
      end
      m_cdiv <= (m_cdiv == COUNT_DIV - 1) ? 0 : m_cdiv + 1;
      m_sdiv <= (m_sdiv == SCAN_DIV - 1) ? 0 : m_sdiv + 1;
      if (m_sdiv == SCAN_DIV - 1) m_idx <= (m_idx == 2) ? 0 : m_idx + 1;
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rstn = 1'b0; en = 1'b0; load = 1'b0; load_val = 12'h000; dp = 3'b000;
    repeat (3) @(negedge clk);
    checks++;
    if ({h_count, h_wrap, h_sel, h_seg} !== {12'h000, 1'b0, 3'b000, 8'h00}) begin
      failures++;
      $display("FAIL reset_hex got=%h exp=%h", {h_count, h_wrap, h_sel, h_seg}, {12'h000, 1'b0, 3'b000, 8'h00});
    end
    checks++;
    if ({d_count, d_wrap, d_sel, d_seg} !== {12'h000, 1'b0, 3'b111, 8'hFF}) begin
      failures++;
      $display("FAIL reset_dec got=%h exp=%h", {d_count, d_wrap, d_sel, d_seg}, {12'h000, 1'b0, 3'b111, 8'hFF});
    end
    rstn = 1'b1;
  endtask

  task automatic test_hex_count();
    logic [11:0] prev;
    bit          saw_f_to_10;
    saw_f_to_10 = 1'b0;
    prev = h_count;
    en = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      checks++;
      if ({h_count, h_wrap, h_sel, h_seg} !== {m_cnt[0], m_wrap[0], m_sel[0], m_seg[0]}) begin
        failures++;
        $display("FAIL hex_count got=%h exp=%h", {h_count, h_wrap, h_sel, h_seg}, {m_cnt[0], m_wrap[0], m_sel[0], m_seg[0]});
      end
      checks++;
      if ({d_count, d_wrap, d_sel, d_seg} !== {m_cnt[1], m_wrap[1], m_sel[1], m_seg[1]}) begin
        failures++;
        $display("FAIL dec_count got=%h exp=%h", {d_count, d_wrap, d_sel, d_seg}, {m_cnt[1], m_wrap[1], m_sel[1], m_seg[1]});
      end
      if (prev == 12'h00F && h_count == 12'h010) saw_f_to_10 = 1'b1;
      prev = h_count;
    end
    checks++;
    if (saw_f_to_10 !== 1'b1) begin
      failures++;
      $display("FAIL hex_00f_to_010 got=%0d exp=1", saw_f_to_10);
    end
  endtask

  task automatic test_decimal_wrap();
    int nwrap;
    nwrap = 0;
    load = 1'b1; load_val = 12'h999;
    @(negedge clk);
    load = 1'b0;
    checks++;
    if (d_count !== 12'h999) begin
      failures++;
      $display("FAIL dec_load999 got=%h exp=999", d_count);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({d_count, d_wrap} !== {m_cnt[1], m_wrap[1]}) begin
        failures++;
        $display("FAIL dec_wrap_step got=%h exp=%h", {d_count, d_wrap}, {m_cnt[1], m_wrap[1]});
      end
      if (d_wrap) begin
        nwrap++;
        checks++;
        if (d_count !== 12'h000) begin
          failures++;
          $display("FAIL dec_wrap_zero got=%h exp=000", d_count);
        end
      end
    end
    checks++;
    if (nwrap != 1) begin
      failures++;
      $display("FAIL dec_wrap_pulses got=%0d exp=1", nwrap);
    end
  endtask

  task automatic test_load_priority();
    bit found;
    found = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge clk);
      if (m_cdiv == COUNT_DIV - 1) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL load_prio_tick got=0 exp=1");
    end
    load = 1'b1; load_val = 12'h123;
    @(negedge clk);
    load = 1'b0;
    checks++;
    if (h_count !== 12'h123) begin
      failures++;
      $display("FAIL load_prio_hex got=%h exp=123", h_count);
    end
    checks++;
    if (d_count !== 12'h123) begin
      failures++;
      $display("FAIL load_prio_dec got=%h exp=123", d_count);
    end
  endtask

  task automatic test_scan_dp();
    logic [7:0] exp_seg;
    en = 1'b0; load = 1'b1; load_val = 12'h321; dp = 3'b010;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      case (h_sel)
        3'b001:  exp_seg = {1'b0, 7'h06};
        3'b010:  exp_seg = {1'b1, 7'h5B};
        3'b100:  exp_seg = {1'b0, 7'h4F};
        default: exp_seg = 8'hXX;
      endcase
      checks++;
      if (h_seg !== exp_seg) begin
        failures++;
        $display("FAIL scan_321 sel=%b got=%h exp=%h", h_sel, h_seg, exp_seg);
      end
      checks++;
      if ({h_sel, h_seg, d_sel, d_seg} !== {m_sel[0], m_seg[0], m_sel[1], m_seg[1]}) begin
        failures++;
        $display("FAIL scan_model got=%h exp=%h", {h_sel, h_seg, d_sel, d_seg}, {m_sel[0], m_seg[0], m_sel[1], m_seg[1]});
      end
    end
    load = 1'b1; load_val = 12'h005; dp = 3'b000;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
`ifdef SVN_SEG_LEAD_ZERO_BLANK_EN
      exp_seg = (h_sel == 3'b001) ? 8'h6D : 8'h00;
`else
      exp_seg = (h_sel == 3'b001) ? 8'h6D : 8'h3F;
`endif
      checks++;
      if (h_seg !== exp_seg) begin
        failures++;
        $display("FAIL lead_zero sel=%b got=%h exp=%h", h_sel, h_seg, exp_seg);
      end
    end
  endtask

  task automatic test_reset_mid();
    en = 1'b1; dp = 3'b101;
    repeat (5) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({h_count, h_wrap, h_sel, h_seg} !== {12'h000, 1'b0, 3'b000, 8'h00}) begin
      failures++;
      $display("FAIL reset_mid_hex got=%h exp=%h", {h_count, h_wrap, h_sel, h_seg}, {12'h000, 1'b0, 3'b000, 8'h00});
    end
    checks++;
    if ({d_count, d_sel, d_seg} !== {12'h000, 3'b111, 8'hFF}) begin
      failures++;
      $display("FAIL reset_mid_dec got=%h exp=%h", {d_count, d_sel, d_seg}, {12'h000, 3'b111, 8'hFF});
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_random();
    logic [11:0] picks [4];
    picks[0] = 12'h999; picks[1] = 12'hFFF; picks[2] = 12'h998; picks[3] = 12'h0FE;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      checks++;
      if ({h_count, h_wrap, h_sel, h_seg} !== {m_cnt[0], m_wrap[0], m_sel[0], m_seg[0]}) begin
        failures++;
        $display("FAIL rand_hex cyc=%0d got=%h exp=%h", i, {h_count, h_wrap, h_sel, h_seg}, {m_cnt[0], m_wrap[0], m_sel[0], m_seg[0]});
      end
      checks++;
      if ({d_count, d_wrap, d_sel, d_seg} !== {m_cnt[1], m_wrap[1], m_sel[1], m_seg[1]}) begin
        failures++;
        $display("FAIL rand_dec cyc=%0d got=%h exp=%h", i, {d_count, d_wrap, d_sel, d_seg}, {m_cnt[1], m_wrap[1], m_sel[1], m_seg[1]});
      end
      en   = ($urandom % 4) != 0;
      load = ($urandom % 12) == 0;
      load_val = ($urandom % 2) ? 12'($urandom) : picks[$urandom % 4];
      dp   = 3'($urandom);
    end
    load = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_hex_count();
    test_decimal_wrap();
    test_load_priority();
    test_scan_dp();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/svn_seg_mux_cntr.md
Name: svn_seg_mux_cntr

Overview:
Parametrised successor to the single-digit 7-segment counter. Maintains a NUM_DIGITS-digit hex or decimal counter with a synchronous load and enable. Time-multiplexes the digits onto one shared segment bus with one-hot digit selects and a per-digit decimal point. Sits in the board-check top level and drives the multi-digit 7-segment header directly.

Parameters:
- NUM_DIGITS, 3: number of displayed digits, 1..8.
- COUNT_DIV, 125_000_000: clk_i cycles per count increment (1 Hz at 125 MHz), must be >= 1.
- SCAN_DIV, 125_000: clk_i cycles per digit scan step (1 kHz), must be >= 1.
- DECIMAL, 1'b0: 0 = hex digits (0..F); 1 = BCD digits (0..9).
- SEG_POLARITY, 1'b0: 1 = segment lit when high; 0 = lit when low.
- SEL_POLARITY, 1'b1: 1 = digit select active high; 0 = active low.

Ports:
- clk_i, in, 1: system clock.
- rstn_i, in, 1: asynchronous active-low reset.
- en_i, in, 1: count enable.
- load_i, in, 1: synchronous load strobe.
- load_val_i, in, 4*NUM_DIGITS: value to load, nibble k = digit k, digit 0 = least significant.
- dp_i, in, NUM_DIGITS: decimal point request, one bit per digit.
- count_o, out, 4*NUM_DIGITS: current counter value.
- wrap_o, out, 1: one-cycle pulse when the counter wraps from all-max to zero.
- seg_display_o, out, 8: bit7 = dp, bits6..0 = g..a, polarity per SEG_POLARITY.
- seg_sel_o, out, NUM_DIGITS: one-hot digit select, polarity per SEL_POLARITY.

Behaviour:
- Reset: clk_i rising edge; rstn_i asynchronous active-low.
- Reset values:
  - count_o = 0, wrap_o = 0.
  - Both prescalers = 0, scan index = 0.
  - seg_display_o = all segments off (8'h00 if SEG_POLARITY=1, else 8'hFF).
  - seg_sel_o = all digits inactive.
- Count prescaler: 0..COUNT_DIV-1, free-running, independent of en_i. count_tick asserts for one cycle at terminal count.
- Scan prescaler: 0..SCAN_DIV-1. scan_tick asserts for one cycle at terminal count.
- Priority, highest first:
  - load_i: count_o <= load_val_i on the next edge. A pending count_tick in the same cycle is dropped. Prescalers are not reset.
  - en_i && count_tick: increment.
  - Otherwise: hold.
- Increment rules:
  - Digit 0 always increments. Digit k increments only when all lower digits are at max.
  - max = 9 (DECIMAL=1) or 15 (DECIMAL=0). A digit at max wraps to 0.
  - DECIMAL=1 with a loaded nibble > 9: the nibble is treated as max and wraps to 0 with carry on its next increment.
- Wrap: when every digit is at max during an increment, all digits become 0 and wrap_o pulses high for exactly that one cycle.
- Scan:
  - On scan_tick, the scan index advances 0 -> 1 -> ... -> NUM_DIGITS-1 -> 0.
  - NUM_DIGITS=1: index stays 0 and the select is permanently active once out of reset.
- Output stage: registered, latency 1 clk after the index or count change.
  - seg_sel_o and seg_display_o update on the same edge; no cycle shows a new select with old segments.
  - seg_display_o = SEG7DISP[digit[idx]] with bit7 = dp_i[idx], then polarity applied.
- Load mid-scan: the displayed digit reflects the new value on the next edge, with no scan disturbance.
- Reset mid-operation: all state returns to reset values immediately.

Optional Feature:
- Macro: SVN_SEG_LEAD_ZERO_BLANK_EN.
- Defined:
  - Any digit above digit 0 whose value and all higher digits' values are 0 is blanked: segments off and dp still honoured.
  - Digit 0 is never blanked; count_o is unaffected.
- Undefined: all digits always displayed, including leading zeros.

Decomposition:
- Package svn_seg_pkg holds:
  - The SEG7DISP[16] segment-pattern constant (bits6..0, active-high, dp clear).
  - The typedef nibble_t (logic [3:0]).
  - The SEG_OFF constant.
- Sub-module svn_seg_digit_cntr, instantiated NUM_DIGITS times via generate:
  - Inputs: clk/rst, load, load nibble, inc, carry_in.
  - Outputs: digit value, at_max.
  - Parameter: DECIMAL.
  - Carry chain: inc_k = inc && &at_max[k-1:0].

Test Plan:
- Hex counting. Bench: NUM_DIGITS=3, COUNT_DIV=4, SCAN_DIV=2, DECIMAL=0, en_i=1.
  -> count_o steps 000, 001, ... every 4 clks; 00F -> 010.
- Decimal wrap. Bench as above with DECIMAL=1; load 999 then enable.
  -> next count_tick gives 000; wrap_o high exactly one cycle.
- Load priority. load_i=1 with load_val_i=12'h123 in the same cycle as count_tick.
  -> count_o = 123 next cycle, not 124.
- Scan order. count_o=321, SEL_POLARITY=1, SEG_POLARITY=1.
  -> seg_sel_o cycles 001, 010, 100 every 2 clks.
  -> seg_display_o = SEG7DISP[1], [2], [3], registered aligned with the select.
- Decimal point. dp_i=3'b010.
  -> seg_display_o[7] = 1 only while seg_sel_o = 010.
- Reset mid-count. Assert rstn_i low asynchronously mid-scan.
  -> count_o = 0, seg_sel_o = 000, seg_display_o = 8'h00 before the next clk edge.
- Blanking, with SVN_SEG_LEAD_ZERO_BLANK_EN defined. count_o = 005.
  -> digits 2 and 1 show 8'h00; digit 0 shows SEG7DISP[5].
